// File: rtl/rob_tag_regfile_pkg.sv
// Shared widths and payload types for the rename-tagged register file.
package rob_tag_regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned NUM_RD    = 2;
    localparam int unsigned NUM_CM    = 2;
    localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);
    localparam int unsigned REG_W     = $clog2(NUM_REGS);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
    } rename_req_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } commit_t;

    // Commit fields a lookup needs: the match is on tag only, never on rd.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cm_src_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] idx;
    } lookup_req_t;

    typedef struct packed {
        logic             ack;
        logic             ready;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } lookup_rsp_t;

endpackage

// File: rtl/rob_tag_bypass.sv
// One operand lookup port: resolves a register's state plus same-cycle commits into a response.
module rob_tag_bypass
    import rob_tag_regfile_pkg::*;
(
    input  lookup_req_t          req,
    input  logic                 busy,
    input  logic [TAG_W-1:0]     tag,
    input  logic [XLEN-1:0]      value,
    input  cm_src_t [NUM_CM-1:0] cm,
    output lookup_rsp_t          rsp
);

    logic            hit;
    logic [XLEN-1:0] hit_data;

    // Youngest (highest-index) commit carrying the pending tag supplies the bypass value.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < NUM_CM; i++) begin
            if (cm[i].valid && (cm[i].tag == tag)) begin
                hit      = 1'b1;
                hit_data = cm[i].data;
            end
        end
    end

    // Priority: x0, committed array value, same-cycle bypass, else report pending tag.
    always_comb begin
        rsp = '0;
        if (req.valid) begin
            rsp.ack = 1'b1;
            if (req.idx == '0) begin
                rsp.ready = 1'b1;
            end else if (!busy) begin
                rsp.ready = 1'b1;
                rsp.data  = value;
            end else if (hit) begin
                rsp.ready = 1'b1;
                rsp.data  = hit_data;
            end else begin
                rsp.tag = tag;
            end
        end
    end

endmodule

// File: rtl/rob_tag_regfile.sv
// Architectural register file with per-register rename tag and busy bit, multi-commit and flush.
module rob_tag_regfile
    import rob_tag_regfile_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ren_valid,
    input  logic [REG_W-1:0]         ren_rd,
    input  logic [TAG_W-1:0]         ren_tag,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*REG_W-1:0]  rd_idx,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    input  logic [NUM_CM-1:0]        cm_valid,
    input  logic [NUM_CM*REG_W-1:0]  cm_rd,
    input  logic [NUM_CM*TAG_W-1:0]  cm_tag,
    input  logic [NUM_CM*XLEN-1:0]   cm_data
);

    logic [XLEN-1:0]     value_q   [NUM_REGS];
    logic [XLEN-1:0]     value_nxt [NUM_REGS];
    logic [TAG_W-1:0]    tag_q     [NUM_REGS];
    logic [TAG_W-1:0]    tag_nxt   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;

    rename_req_t          ren;
    commit_t [NUM_CM-1:0] cm;
    cm_src_t [NUM_CM-1:0] byp_src;

    // Unpack flat port buses into payload structs.
    always_comb begin
        ren.valid = ren_valid;
        ren.rd    = ren_rd;
        ren.tag   = ren_tag;
        for (int unsigned c = 0; c < NUM_CM; c++) begin
            cm[c].valid      = cm_valid[c];
            cm[c].rd         = cm_rd[c*REG_W +: REG_W];
            cm[c].tag        = cm_tag[c*TAG_W +: TAG_W];
            cm[c].data       = cm_data[c*XLEN +: XLEN];
            byp_src[c].valid = cm[c].valid;
            byp_src[c].tag   = cm[c].tag;
            byp_src[c].data  = cm[c].data;
        end
    end

    // Next state: commits in port order (younger overrides), then flush or rename on top.
    always_comb begin
        value_nxt = value_q;
        tag_nxt   = tag_q;
        busy_nxt  = busy_q;
        for (int unsigned c = 0; c < NUM_CM; c++) begin
            if (cm[c].valid && (cm[c].rd != '0)) begin
                value_nxt[cm[c].rd] = cm[c].data;
                busy_nxt[cm[c].rd]  = (tag_q[cm[c].rd] == cm[c].tag) ? 1'b0 : busy_q[cm[c].rd];
            end
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (ren.valid && (ren.rd != '0)) begin
            tag_nxt[ren.rd]  = ren.tag;
            busy_nxt[ren.rd] = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '{default: '0};
            tag_q   <= '{default: '0};
            busy_q  <= '0;
        end else begin
            value_q <= value_nxt;
            tag_q   <= tag_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // One bypass resolver per lookup port, fed with the indexed register's current state.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        lookup_req_t req;
        lookup_rsp_t rsp;

        assign req.valid = rd_req[p];
        assign req.idx   = rd_idx[p*REG_W +: REG_W];

        rob_tag_bypass u_bypass (
            .req   (req),
            .busy  (busy_q[req.idx]),
            .tag   (tag_q[req.idx]),
            .value (value_q[req.idx]),
            .cm    (byp_src),
            .rsp   (rsp)
        );

        assign rd_ack[p]                 = rsp.ack;
        assign rd_ready[p]               = rsp.ready;
        assign rd_data[p*XLEN +: XLEN]   = rsp.data;
        assign rd_tag[p*TAG_W +: TAG_W]  = rsp.tag;
    end

endmodule

// File: tb/tb_rob_tag_regfile.sv
// Directed bench for rob_tag_regfile: rename, commit, bypass, stale tags, flush.
module tb_rob_tag_regfile;
    import rob_tag_regfile_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    ren_valid;
    logic [REG_W-1:0]        ren_rd;
    logic [TAG_W-1:0]        ren_tag;
    logic [NUM_RD-1:0]       rd_req;
    logic [NUM_RD*REG_W-1:0] rd_idx;
    logic [NUM_RD-1:0]       rd_ack;
    logic [NUM_RD-1:0]       rd_ready;
    logic [NUM_RD*XLEN-1:0]  rd_data;
    logic [NUM_RD*TAG_W-1:0] rd_tag;
    logic [NUM_CM-1:0]       cm_valid;
    logic [NUM_CM*REG_W-1:0] cm_rd;
    logic [NUM_CM*TAG_W-1:0] cm_tag;
    logic [NUM_CM*XLEN-1:0]  cm_data;

    int n_cmp = 0;
    int n_err = 0;

    rob_tag_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ren_valid (ren_valid),
        .ren_rd    (ren_rd),
        .ren_tag   (ren_tag),
        .rd_req    (rd_req),
        .rd_idx    (rd_idx),
        .rd_ack    (rd_ack),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .cm_valid  (cm_valid),
        .cm_rd     (cm_rd),
        .cm_tag    (cm_tag),
        .cm_data   (cm_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_port(input string name, input int p, input logic exp_ready,
                            input logic [31:0] exp_data, input logic [31:0] exp_tag);
        chk({name, ".ack"}, 32'(rd_ack[p]), 32'd1);
        chk({name, ".ready"}, 32'(rd_ready[p]), 32'(exp_ready));
        if (exp_ready) chk({name, ".data"}, rd_data[p*XLEN +: XLEN], exp_data);
        else           chk({name, ".tag"}, 32'(rd_tag[p*TAG_W +: TAG_W]), exp_tag);
    endtask

    task automatic chk_idle(input string name, input int p);
        chk({name, ".ack"}, 32'(rd_ack[p]), 32'd0);
        chk({name, ".ready"}, 32'(rd_ready[p]), 32'd0);
        chk({name, ".data"}, rd_data[p*XLEN +: XLEN], 32'd0);
        chk({name, ".tag"}, 32'(rd_tag[p*TAG_W +: TAG_W]), 32'd0);
    endtask

    task automatic clear_inputs();
        flush     = 1'b0;
        ren_valid = 1'b0;
        ren_rd    = '0;
        ren_tag   = '0;
        rd_req    = '0;
        rd_idx    = '0;
        cm_valid  = '0;
        cm_rd     = '0;
        cm_tag    = '0;
        cm_data   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic look(input int p, input int idx);
        rd_req[p]              = 1'b1;
        rd_idx[p*REG_W +: REG_W] = REG_W'(idx);
    endtask

    task automatic rename(input int r, input int t);
        ren_valid = 1'b1;
        ren_rd    = REG_W'(r);
        ren_tag   = TAG_W'(t);
    endtask

    task automatic commit(input int c, input int r, input int t, input logic [31:0] d);
        cm_valid[c]              = 1'b1;
        cm_rd[c*REG_W +: REG_W]  = REG_W'(r);
        cm_tag[c*TAG_W +: TAG_W] = TAG_W'(t);
        cm_data[c*XLEN +: XLEN]  = d;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state: lookups see zero, unused port is all zero.
        look(0, 5);
        settle();
        chk_port("rst_x5", 0, 1'b1, 32'h0, 32'h0);
        chk_idle("rst_idle_p1", 1);
        rst = 1'b0;
        tick();

        // x0 stays zero after a commit to it.
        commit(0, 0, 0, 32'h7);
        tick();
        look(0, 0);
        settle();
        chk_port("x0_after_commit", 0, 1'b1, 32'h0, 32'h0);

        // Rename then pending lookup, same-cycle bypass, then array value.
        tick();
        rename(3, 4);
        tick();
        look(0, 3);
        settle();
        chk_port("x3_pending", 0, 1'b0, 32'h0, 32'd4);
        commit(0, 3, 4, 32'hAB);
        settle();
        chk_port("x3_bypass", 0, 1'b1, 32'hAB, 32'h0);
        tick();
        look(0, 3);
        settle();
        chk_port("x3_array", 0, 1'b1, 32'hAB, 32'h0);

        // Double rename: stale-tag commit writes value but must not satisfy lookup.
        tick();
        rename(3, 4);
        tick();
        rename(3, 9);
        tick();
        commit(1, 3, 4, 32'h11);
        look(0, 3);
        settle();
        chk_port("x3_stale_bypass", 0, 1'b0, 32'h0, 32'd9);
        tick();
        look(0, 3);
        settle();
        chk_port("x3_still_busy", 0, 1'b0, 32'h0, 32'd9);
        commit(0, 3, 9, 32'h22);
        settle();
        chk_port("x3_tag9_bypass", 0, 1'b1, 32'h22, 32'h0);
        tick();
        look(0, 3);
        settle();
        chk_port("x3_tag9_array", 0, 1'b1, 32'h22, 32'h0);

        // Commit and rename of the same reg in one cycle: rename wins busy, value written.
        tick();
        rename(3, 4);
        tick();
        commit(0, 3, 4, 32'h33);
        rename(3, 12);
        tick();
        look(0, 3);
        settle();
        chk_port("x3_rename_wins", 0, 1'b0, 32'h0, 32'd12);
        flush = 1'b1;
        tick();
        look(1, 3);
        settle();
        chk_port("x3_value_kept", 1, 1'b1, 32'h33, 32'h0);

        // Two commits to x7: younger port wins value and tag compare.
        tick();
        rename(7, 2);
        tick();
        rename(7, 3);
        tick();
        commit(0, 7, 2, 32'h1);
        commit(1, 7, 3, 32'h2);
        look(0, 7);
        settle();
        chk_port("x7_dual_bypass", 0, 1'b1, 32'h2, 32'h0);
        tick();
        look(0, 7);
        look(1, 3);
        settle();
        chk_port("x7_dual_array", 0, 1'b1, 32'h2, 32'h0);
        chk_port("x3_port1", 1, 1'b1, 32'h33, 32'h0);

        // Flush with a same-cycle rename and commit.
        tick();
        commit(0, 2, 0, 32'h99);
        tick();
        rename(1, 5);
        tick();
        rename(2, 6);
        tick();
        look(0, 1);
        look(1, 2);
        settle();
        chk_port("x1_pre_flush", 0, 1'b0, 32'h0, 32'd5);
        chk_port("x2_pre_flush", 1, 1'b0, 32'h0, 32'd6);
        rd_req = '0;
        flush  = 1'b1;
        rename(4, 7);
        commit(0, 1, 5, 32'h5);
        tick();
        look(0, 1);
        look(1, 2);
        settle();
        chk_port("x1_post_flush", 0, 1'b1, 32'h5, 32'h0);
        chk_port("x2_post_flush", 1, 1'b1, 32'h99, 32'h0);
        tick();
        look(0, 4);
        settle();
        chk_port("x4_rename_dropped", 0, 1'b1, 32'h0, 32'h0);
        chk_idle("idle_p1_end", 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
